// File: rtl/sdram_port_arbiter.sv
// Small circular FIFO with occupancy count; one-cycle push-to-visible latency.
// Push when full and pop when empty are dropped; the caller decides flow control.
module tag_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic [W-1:0]                 push_dat_i,
    input  logic                         pop_i,
    output logic [W-1:0]                 pop_dat_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        do_push  = push_i && (count_q != CW'(DEPTH));
        do_pop   = pop_i && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        // Explicit wrap keeps DEPTH=1 correct as well as powers of two.
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_dat_i;
            end
        end
    end

    assign pop_dat_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;
endmodule

// Round-robin share of one SDRAM command port; 3 cycles min per command, ack 1 cycle after handshake.
// Holds the command while cmd_ready is low; reads are masked while RD_DEPTH reads are outstanding.
module sdram_port_arbiter #(
    parameter int NPORTS   = 3,
    parameter int AW       = 24,
    parameter int DW       = 16,
    parameter int RD_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 locked,
    input  logic [NPORTS-1:0]    p_req,
    input  logic [NPORTS-1:0]    p_we,
    input  logic [NPORTS*AW-1:0] p_addr,
    input  logic [NPORTS*DW-1:0] p_wdata,
    output logic [NPORTS-1:0]    p_ack,
    output logic [NPORTS-1:0]    p_rvalid,
    output logic [DW-1:0]        p_rdata,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic                 cmd_we,
    output logic [AW-1:0]        cmd_addr,
    output logic [DW-1:0]        cmd_wdata,
    input  logic                 rd_valid,
    input  logic [DW-1:0]        rd_data,
    output logic                 err
);
    localparam int GW = $clog2(NPORTS);
    localparam int CW = $clog2(RD_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ACK   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [GW-1:0]      last_grant_q, last_grant_d;
    logic [GW-1:0]      owner_q, owner_d;
    logic               cmd_valid_q, cmd_valid_d;
    logic               cmd_we_q, cmd_we_d;
    logic [AW-1:0]      cmd_addr_q, cmd_addr_d;
    logic [DW-1:0]      cmd_wdata_q, cmd_wdata_d;
    logic [NPORTS-1:0]  p_ack_q, p_ack_d;
    logic [NPORTS-1:0]  p_rvalid_q, p_rvalid_d;
    logic [DW-1:0]      p_rdata_q, p_rdata_d;
    logic               err_q, err_d;

    logic [NPORTS-1:0]  eligible;
    logic               found;
    logic [GW-1:0]      winner;
    int                 idx;
    logic               tag_push, tag_pop;
    logic [GW-1:0]      tag_out;
    logic [CW-1:0]      rd_count;

    tag_fifo #(
        .W     (GW),
        .DEPTH (RD_DEPTH)
    ) u_tag_fifo (
        .clk        (clk),
        .rst_n      (locked),
        .push_i     (tag_push),
        .push_dat_i (owner_q),
        .pop_i      (tag_pop),
        .pop_dat_o  (tag_out),
        .count_o    (rd_count)
    );

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NPORTS; i++) begin
            eligible[i] = p_req[i] & (p_we[i] | (rd_count < CW'(RD_DEPTH)));
        end
    end

    // Search starts one past the previous winner so every port gets a turn.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 1; k <= NPORTS; k++) begin
            idx = (int'(last_grant_q) + k) % NPORTS;
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = GW'(idx);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        cmd_valid_d  = cmd_valid_q;
        cmd_we_d     = cmd_we_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_wdata_d  = cmd_wdata_q;
        p_ack_d      = '0;
        tag_push     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    owner_d      = winner;
                    last_grant_d = winner;
                    cmd_we_d     = p_we[winner];
                    cmd_addr_d   = p_addr[int'(winner)*AW +: AW];
                    cmd_wdata_d  = p_wdata[int'(winner)*DW +: DW];
                    cmd_valid_d  = 1'b1;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_valid_q && cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    p_ack_d     = NPORTS'(1) << owner_q;
                    tag_push    = !cmd_we_q;
                    state_d     = ACK;
                end
            end
            ACK: begin
                // Dead cycle lets the owner drop p_req before the next decision.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        tag_pop    = rd_valid && (rd_count != '0);
        p_rvalid_d = tag_pop ? (NPORTS'(1) << tag_out) : '0;
        p_rdata_d  = tag_pop ? rd_data : p_rdata_q;
        err_d      = err_q | (rd_valid && (rd_count == '0));
    end

    always_ff @(posedge clk or negedge locked) begin
        if (!locked) begin
            state_q      <= IDLE;
            last_grant_q <= GW'(NPORTS - 1);
            owner_q      <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_we_q     <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_wdata_q  <= '0;
            p_ack_q      <= '0;
            p_rvalid_q   <= '0;
            p_rdata_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_we_q     <= cmd_we_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_wdata_q  <= cmd_wdata_d;
            p_ack_q      <= p_ack_d;
            p_rvalid_q   <= p_rvalid_d;
            p_rdata_q    <= p_rdata_d;
            err_q        <= err_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_we    = cmd_we_q;
    assign cmd_addr  = cmd_addr_q;
    assign cmd_wdata = cmd_wdata_q;
    assign p_ack     = p_ack_q;
    assign p_rvalid  = p_rvalid_q;
    assign p_rdata   = p_rdata_q;
    assign err       = err_q;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: queue-based reference model checked every cycle,
// plus literal expectations on grant order, read routing, stalls and reset.
module tb_sdram_port_arbiter;
    localparam int NP  = 3;
    localparam int AW  = 24;
    localparam int DW  = 16;
    localparam int RDD = 4;

    logic               clk = 1'b0;
    logic               locked = 1'b0;
    logic [NP-1:0]      p_req = '0;
    logic [NP-1:0]      p_we = '0;
    logic [NP*AW-1:0]   p_addr = '0;
    logic [NP*DW-1:0]   p_wdata = '0;
    logic [NP-1:0]      p_ack;
    logic [NP-1:0]      p_rvalid;
    logic [DW-1:0]      p_rdata;
    logic               cmd_valid;
    logic               cmd_ready = 1'b1;
    logic               cmd_we;
    logic [AW-1:0]      cmd_addr;
    logic [DW-1:0]      cmd_wdata;
    logic               rd_valid = 1'b0;
    logic [DW-1:0]      rd_data = '0;
    logic               err;

    always #5 clk = ~clk;

    sdram_port_arbiter #(
        .NPORTS   (NP),
        .AW       (AW),
        .DW       (DW),
        .RD_DEPTH (RDD)
    ) dut (
        .clk       (clk),
        .locked    (locked),
        .p_req     (p_req),
        .p_we      (p_we),
        .p_addr    (p_addr),
        .p_wdata   (p_wdata),
        .p_ack     (p_ack),
        .p_rvalid  (p_rvalid),
        .p_rdata   (p_rdata),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .err       (err)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: command slot, one-cycle cool-down after an ack, tag queue.
    logic          m_cmd_valid = 1'b0;
    logic          m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    int            m_owner = 0;
    logic          m_cool = 1'b0;
    logic [NP-1:0] m_ack = '0;
    logic [NP-1:0] m_rv = '0;
    logic [DW-1:0] m_rdata = '0;
    logic          m_err = 1'b0;
    int            m_last = NP - 1;
    int            m_cnt, m_t, m_base;
    int            tagq[$];

    initial forever begin
        @(posedge clk or negedge locked);
        if (!locked) begin
            m_cmd_valid = 1'b0;
            m_we = 1'b0;
            m_addr = '0;
            m_wdata = '0;
            m_owner = 0;
            m_cool = 1'b0;
            m_ack = '0;
            m_rv = '0;
            m_rdata = '0;
            m_err = 1'b0;
            m_last = NP - 1;
            tagq.delete();
        end else begin
            m_cnt = tagq.size();
            m_ack = '0;
            m_rv  = '0;
            if (rd_valid) begin
                if (m_cnt > 0) begin
                    m_t = tagq.pop_front();
                    m_rv[m_t] = 1'b1;
                    m_rdata = rd_data;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (m_cool) begin
                m_cool = 1'b0;
            end else if (m_cmd_valid) begin
                if (cmd_ready) begin
                    if (!m_we) tagq.push_back(m_owner);
                    m_ack[m_owner] = 1'b1;
                    m_cmd_valid = 1'b0;
                    m_cool = 1'b1;
                end
            end else begin
                m_base = m_last;
                for (int k = 1; k <= NP; k++) begin
                    m_t = (m_base + k) % NP;
                    if (!m_cmd_valid && p_req[m_t] && (p_we[m_t] || m_cnt < RDD)) begin
                        m_cmd_valid = 1'b1;
                        m_owner = m_t;
                        m_last = m_t;
                        m_we = p_we[m_t];
                        m_addr = p_addr[m_t*AW +: AW];
                        m_wdata = p_wdata[m_t*DW +: DW];
                    end
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        chk("cmd_valid", 32'(cmd_valid), 32'(m_cmd_valid));
        if (m_cmd_valid) begin
            chk("cmd_we", 32'(cmd_we), 32'(m_we));
            chk("cmd_addr", 32'(cmd_addr), 32'(m_addr));
            chk("cmd_wdata", 32'(cmd_wdata), 32'(m_wdata));
        end
        chk("p_ack", 32'(p_ack), 32'(m_ack));
        chk("p_rvalid", 32'(p_rvalid), 32'(m_rv));
        chk("p_rdata", 32'(p_rdata), 32'(m_rdata));
        chk("err", 32'(err), 32'(m_err));
        chk("ack_onehot", 32'($countones(p_ack) <= 1), 32'(1));
    end

    // Requester behaviour: drop p_req on ack, optionally re-raise one cycle later.
    logic [NP-1:0] rereq = '0;
    logic [NP-1:0] pend = '0;
    logic [NP-1:0] ack_seen = '0;
    int            ack_log[$];
    int            ack_cyc[$];

    task automatic tick();
        @(negedge clk);
        cyc++;
        ack_seen = p_ack;
        for (int i = 0; i < NP; i++) begin
            if (p_ack[i]) begin
                p_req[i] = 1'b0;
                ack_log.push_back(i);
                ack_cyc.push_back(cyc);
                if (rereq[i]) pend[i] = 1'b1;
            end else if (pend[i]) begin
                p_req[i] = 1'b1;
                pend[i] = 1'b0;
            end
        end
    endtask

    task automatic set_port(input int i, input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
        p_we[i] = we;
        p_addr[i*AW +: AW] = a;
        p_wdata[i*DW +: DW] = d;
    endtask

    task automatic wait_cmd(input string nm);
        for (int n = 0; n < 20 && !cmd_valid; n++) tick();
        chk(nm, 32'(cmd_valid), 32'(1));
    endtask

    task automatic wait_ack(input string nm, input int port);
        logic got;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            tick();
            got = ack_seen[port];
        end
        chk(nm, 32'(got), 32'(1));
    endtask

    task automatic drain_reqs();
        for (int n = 0; n < 60 && p_req != '0; n++) tick();
        chk("drain_reqs", 32'(p_req), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    logic [NP-1:0] acc;
    int            ord[3];
    logic [DW-1:0] rdv[3];

    initial begin
        tick();
        tick();
        chk("rst_cmd_valid", 32'(cmd_valid), 32'(0));
        chk("rst_p_ack", 32'(p_ack), 32'(0));
        chk("rst_p_rvalid", 32'(p_rvalid), 32'(0));
        chk("rst_p_rdata", 32'(p_rdata), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        locked = 1'b1;
        tick();

        // Round robin among three continuous writers.
        for (int i = 0; i < NP; i++) set_port(i, 1'b1, AW'(24'h100 + i), DW'(16'hA0 + i));
        ack_log.delete();
        ack_cyc.delete();
        rereq = '1;
        p_req = '1;
        for (int n = 0; n < 60 && ack_log.size() < 6; n++) tick();
        chk("rr_count", 32'(ack_log.size() >= 6), 32'(1));
        if (ack_log.size() >= 6) begin
            for (int j = 0; j < 6; j++) chk($sformatf("rr_order%0d", j), 32'(ack_log[j]), 32'(j % 3));
            for (int j = 1; j < 6; j++) chk($sformatf("rr_gap%0d", j), 32'(ack_cyc[j] - ack_cyc[j-1]), 32'(3));
        end
        rereq = '0;
        pend = '0;
        drain_reqs();

        // Single read from port 0 and its data return.
        set_port(0, 1'b0, 24'h012345, 16'h0);
        p_req[0] = 1'b1;
        wait_cmd("rd0_cmd");
        chk("rd0_addr", 32'(cmd_addr), 32'h012345);
        chk("rd0_we", 32'(cmd_we), 32'(0));
        wait_ack("rd0_ack", 0);
        tick();
        tick();
        tick();
        rd_valid = 1'b1;
        rd_data = 16'hBEEF;
        tick();
        rd_valid = 1'b0;
        chk("rd0_rvalid", 32'(p_rvalid), 32'b001);
        chk("rd0_rdata", 32'(p_rdata), 32'hBEEF);
        tick();
        chk("rd0_rvalid_pulse", 32'(p_rvalid), 32'b000);

        // Four outstanding reads from port 1 mask its fifth read; port 2 write passes.
        for (int j = 0; j < 4; j++) begin
            set_port(1, 1'b0, AW'(24'h200 + j), 16'h0);
            p_req[1] = 1'b1;
            wait_ack($sformatf("full_rd%0d", j), 1);
        end
        set_port(1, 1'b0, 24'h000300, 16'h0);
        set_port(2, 1'b1, 24'h000400, 16'h4444);
        p_req[1] = 1'b1;
        p_req[2] = 1'b1;
        wait_ack("full_wr_p2", 2);
        acc = '0;
        for (int n = 0; n < 6; n++) begin
            tick();
            acc |= ack_seen;
        end
        chk("full_p1_blocked", 32'(acc[1]), 32'(0));
        rd_valid = 1'b1;
        rd_data = 16'hA000;
        tick();
        rd_valid = 1'b0;
        chk("full_pop_rvalid", 32'(p_rvalid), 32'b010);
        wait_ack("full_p1_granted", 1);
        for (int j = 0; j < 4; j++) begin
            rd_valid = 1'b1;
            rd_data = DW'(16'hA001 + j);
            tick();
            chk($sformatf("full_drain_rv%0d", j), 32'(p_rvalid), 32'b010);
            chk($sformatf("full_drain_rd%0d", j), 32'(p_rdata), 32'(16'hA001 + j));
        end
        rd_valid = 1'b0;
        tick();

        // Stall with cmd_ready low: command held stable, ack only after ready.
        cmd_ready = 1'b0;
        set_port(0, 1'b1, 24'hABCDEF, 16'h5A5A);
        p_req[0] = 1'b1;
        wait_cmd("stall_cmd");
        for (int j = 0; j < 5; j++) begin
            tick();
            chk("stall_valid", 32'(cmd_valid), 32'(1));
            chk("stall_addr", 32'(cmd_addr), 32'hABCDEF);
            chk("stall_wdata", 32'(cmd_wdata), 32'h5A5A);
            chk("stall_noack", 32'(p_ack), 32'(0));
        end
        cmd_ready = 1'b1;
        tick();
        chk("stall_ack", 32'(ack_seen), 32'b001);
        chk("stall_valid_drop", 32'(cmd_valid), 32'(0));
        tick();

        // In-order routing of reads from ports 2, 0, 1; an extra strobe sets err.
        ord = '{2, 0, 1};
        rdv = '{16'h1111, 16'h2222, 16'h3333};
        for (int j = 0; j < 3; j++) begin
            set_port(ord[j], 1'b0, AW'(24'h500 + j), 16'h0);
            p_req[ord[j]] = 1'b1;
            wait_ack($sformatf("ord_ack%0d", j), ord[j]);
        end
        for (int j = 0; j < 3; j++) begin
            rd_valid = 1'b1;
            rd_data = rdv[j];
            tick();
            chk($sformatf("ord_rv%0d", j), 32'(p_rvalid), 32'(1 << ord[j]));
            chk($sformatf("ord_rd%0d", j), 32'(p_rdata), 32'(rdv[j]));
        end
        rd_data = 16'h4444;
        tick();
        rd_valid = 1'b0;
        chk("extra_rv", 32'(p_rvalid), 32'(0));
        chk("extra_err", 32'(err), 32'(1));
        chk("extra_rdata_hold", 32'(p_rdata), 32'h3333);
        tick();
        chk("err_sticky", 32'(err), 32'(1));

        // Reset while a port 1 command is stalled in flight.
        cmd_ready = 1'b0;
        set_port(1, 1'b0, 24'h000777, 16'h0);
        p_req[1] = 1'b1;
        wait_cmd("lk_cmd");
        #2;
        locked = 1'b0;
        p_req = '0;
        #1;
        chk("lk_valid_drop", 32'(cmd_valid), 32'(0));
        chk("lk_err_clr", 32'(err), 32'(0));
        chk("lk_ack", 32'(p_ack), 32'(0));
        tick();
        locked = 1'b1;
        cmd_ready = 1'b1;
        tick();
        rd_valid = 1'b1;
        rd_data = 16'h7777;
        tick();
        rd_valid = 1'b0;
        chk("lk_fifo_empty_rv", 32'(p_rvalid), 32'(0));
        chk("lk_fifo_empty_err", 32'(err), 32'(1));
        for (int i = 0; i < NP; i++) set_port(i, 1'b1, AW'(24'h600 + i), DW'(16'hC0 + i));
        ack_log.delete();
        p_req = '1;
        for (int n = 0; n < 20 && ack_log.size() < 1; n++) tick();
        chk("lk_first_count", 32'(ack_log.size() >= 1), 32'(1));
        if (ack_log.size() >= 1) chk("lk_first_port0", 32'(ack_log[0]), 32'(0));
        drain_reqs();
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single command interface of the SDRAM controller between NPORTS requesters, e.g. video scan-out, the LED/status logic and a test writer.
- Round-robin grant, one command in flight at the arbiter, in-order read-return routing via a tag FIFO.
- Sits between the requesters and the SDRAM controller inside top. Runs in the clk domain.

Parameters:
NPORTS, 3, number of requester ports (2..4)
AW, 24, word address width (bank 2 + row 13 + col 9)
DW, 16, data width (matches SDRAM_DQ)
RD_DEPTH, 4, max reads issued but not yet returned (power of 2)

Ports:
clk  in  1  system clock
locked  in  1  asynchronous active-low reset (PLL lock; low = reset)
p_req  in  NPORTS  per-port request; held until p_ack
p_we  in  NPORTS  per-port 1=write 0=read
p_addr  in  NPORTS*AW  per-port address, port i at [i*AW +: AW]
p_wdata  in  NPORTS*DW  per-port write data
p_ack  out  NPORTS  one-cycle pulse: command accepted by controller
p_rvalid  out  NPORTS  one-cycle pulse: p_rdata valid for that port
p_rdata  out  DW  shared read data
cmd_valid  out  1  command to controller
cmd_ready  in  1  controller accepts command
cmd_we  out  1  write flag
cmd_addr  out  AW  address
cmd_wdata  out  DW  write data
rd_valid  in  1  controller read-data strobe (in issue order)
rd_data  in  DW  controller read data
err  out  1  sticky: rd_valid with empty tag FIFO

Behaviour:
- Reset (locked low, async): state=IDLE; all outputs 0; last_grant=NPORTS-1 so port 0 has priority first; tag FIFO cleared; err=0. A command in flight when locked drops is abandoned; cmd_valid falls immediately.
- FSM IDLE -> ISSUE -> ACK -> IDLE.
- IDLE:
  - eligible[i] = p_req[i] & (p_we[i] | rd_count<RD_DEPTH).
  - Winner = first eligible index searching last_grant+1, last_grant+2, ... modulo NPORTS.
  - If any port is eligible: register cmd_we/addr/wdata from the winner, owner=winner, last_grant=winner, cmd_valid=1 next cycle, go ISSUE.
  - Else stay IDLE.
- ISSUE: hold cmd_* stable while cmd_valid & !cmd_ready. On cmd_valid & cmd_ready (cycle k):
  - cmd_valid=0 at k+1.
  - p_ack[owner]=1 for cycle k+1 only.
  - If read, push owner into the tag FIFO at k.
  - Go ACK.
- ACK: one cycle, no arbitration, so the owner can drop p_req; then IDLE. Minimum spacing is 3 cycles per command. At most one p_ack bit is high in any cycle.
- Read return:
  - rd_valid at cycle r with FIFO non-empty: pop tag t; p_rvalid[t]=1 and p_rdata=rd_data at r+1.
  - p_rdata holds its value otherwise. p_rvalid is 0 otherwise.
- Push and pop in the same cycle are both honoured; rd_count is unchanged.
- rd_count counts pushed-but-not-popped tags (0..RD_DEPTH). When rd_count==RD_DEPTH, read requests are masked and write requests still arbitrate.
- Tag FIFO pointers wrap modulo RD_DEPTH. rd_valid with rd_count==0: ignored, no p_rvalid, err=1 until reset.
- A requester dropping p_req before p_ack is a protocol violation. After the IDLE decision the registered command issues regardless.
- No output is combinational from inputs except through async reset.

Test Plan:
- Port 0 read addr 0x012345; cmd_ready high; rd_valid with 0xBEEF 4 cycles later -> cmd_valid pulse with cmd_addr=0x012345, cmd_we=0; p_ack[0] 1 cycle after the handshake; p_rvalid[0]=1 with p_rdata=0xBEEF one cycle after rd_valid.
- Ports 0, 1, 2 all request continuously, each dropping p_req on ack then re-requesting -> grant order 0,1,2,0,1,2; one ack per 3 cycles; never two acks in the same cycle.
- Port 1 issues 4 reads with no rd_valid, then port 1 read and port 2 write both pending -> port 2 write granted, port 1 blocked. After one rd_valid, port 1 is granted.
- cmd_ready low for 5 cycles during ISSUE -> cmd_valid, cmd_addr and cmd_wdata stay stable; ack only after cmd_ready goes high.
- Reads from ports 2, 0, 1 issued, then 3 rd_valid with 0x1111/0x2222/0x3333 -> p_rvalid[2], [0], [1] fire in order with the matching data. A fourth rd_valid -> err=1, no p_rvalid.
- locked dropped while in ISSUE with cmd_valid=1 -> cmd_valid=0 immediately, FIFO empty. After locked rises, port 0 wins first.
